// File: rtl/cache_controller_if.sv
// rtl/cache_controller_if.sv - MEM-stage request, SRAM-controller and statistics signals of the data cache
interface cache_controller_if #(
    parameter int ADDR_W = 19,
    parameter int CNT_W  = 16
);
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] address;
    logic [31:0]       write_data;
    logic              invalidate;
    logic [31:0]       read_data;
    logic              ready;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [63:0]       mem_rdata;
    logic              mem_ready;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport slave (
        input  rd_en, wr_en, address, write_data, invalidate, mem_rdata, mem_ready,
        output read_data, ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        hit_count, miss_count
    );

    modport master (
        output rd_en, wr_en, address, write_data, invalidate, mem_rdata, mem_ready,
        input  read_data, ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        hit_count, miss_count
    );
endinterface

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - 2-way set-associative write-through, no-write-allocate data cache
module cache_controller #(
    parameter int ADDR_W   = 19,
    parameter int SET_BITS = 6,
    parameter int CNT_W    = 16
) (
    input logic              clk,
    input logic              rst,
    cache_controller_if.slave bus
);
    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = ADDR_W - SET_BITS - 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WRITE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0][SETS-1:0] valid_q;
    logic [SETS-1:0]      lru_q;
    logic [TAG_W-1:0]     tag_q  [2][SETS];
    logic [63:0]          data_q [2][SETS];

    logic              mem_rd_en_q, mem_rd_en_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic              word_q,      word_d;
    logic [CNT_W-1:0]  hit_cnt_q,   hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q,  miss_cnt_d;

    logic [SET_BITS-1:0] idx;
    logic [TAG_W-1:0]    tag;
    logic                word;
    logic                hit0, hit1, hit, hit_way;
    logic                is_rd, rd_hit, rd_miss, wr_hit, do_inv, fill;
    logic [SET_BITS-1:0] fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic                victim;
    logic [63:0]         hit_line;
    logic [31:0]         hit_word, fill_word;
    logic                ready_c;
    logic [31:0]         rdata_c;
    logic [1:0]          unused_addr;

    assign idx         = bus.address[SET_BITS+2:3];
    assign tag         = bus.address[ADDR_W-1:SET_BITS+3];
    assign word        = bus.address[2];
    assign unused_addr = bus.address[1:0];

    assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit     = hit0 || hit1;
    assign hit_way = hit1;

    // wr_en dominates rd_en, so a read is only a read when no store is present
    assign is_rd   = bus.rd_en && !bus.wr_en;
    assign rd_hit  = (state_q == IDLE) && is_rd && hit;
    assign rd_miss = (state_q == IDLE) && is_rd && !hit;
    assign wr_hit  = (state_q == IDLE) && bus.wr_en && hit;
    assign do_inv  = (state_q == IDLE) && !bus.rd_en && !bus.wr_en && bus.invalidate;
    assign fill    = (state_q == RD_MISS) && bus.mem_ready;

    // The fill uses the captured line address, not the live request bus
    assign fill_idx = mem_addr_q[SET_BITS+2:3];
    assign fill_tag = mem_addr_q[ADDR_W-1:SET_BITS+3];
    assign victim   = lru_q[fill_idx];

    assign hit_line  = hit_way ? data_q[1][idx] : data_q[0][idx];
    assign hit_word  = word ? hit_line[63:32] : hit_line[31:0];
    assign fill_word = word_q ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_addr_q  <= '0;
            word_q      <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_addr_q  <= mem_addr_d;
            word_q      <= word_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.wr_en)
                    state_d = WRITE;
                else if (rd_miss)
                    state_d = RD_MISS;
            end
            RD_MISS, WRITE: begin
                if (bus.mem_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_c = 1'b0;
        rdata_c = '0;
        unique case (state_q)
            IDLE: begin
                if (!bus.rd_en && !bus.wr_en) begin
                    ready_c = 1'b1;
                end else if (rd_hit) begin
                    ready_c = 1'b1;
                    rdata_c = hit_word;
                end
            end
            RD_MISS: begin
                if (bus.mem_ready) begin
                    ready_c = 1'b1;
                    rdata_c = fill_word;
                end
            end
            WRITE: begin
                if (bus.mem_ready)
                    ready_c = 1'b1;
            end
            default: ready_c = 1'b0;
        endcase
    end

    always_comb begin
        mem_rd_en_d = (state_d == RD_MISS);
        mem_wr_en_d = (state_d == WRITE);
        mem_addr_d  = mem_addr_q;
        word_d      = word_q;
        if ((state_q == IDLE) && (state_d != IDLE)) begin
            if (bus.wr_en)
                mem_addr_d = {bus.address[ADDR_W-1:2], 2'b00};
            else
                mem_addr_d = {bus.address[ADDR_W-1:3], 3'b000};
            word_d = word;
        end
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (rd_hit && (hit_cnt_q != {CNT_W{1'b1}}))
            hit_cnt_d = hit_cnt_q + 1'b1;
        if (rd_miss && (miss_cnt_q != {CNT_W{1'b1}}))
            miss_cnt_d = miss_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            lru_q   <= '0;
        end else begin
            if (do_inv) begin
                valid_q <= '0;
            end else if (fill) begin
                valid_q[victim][fill_idx] <= 1'b1;
                lru_q[fill_idx]           <= ~victim;
            end else if (rd_hit || wr_hit) begin
                lru_q[idx] <= ~hit_way;
            end
        end
    end

    // Tags and data need no reset: nothing reads them until the valid bit is set
    always_ff @(posedge clk) begin
        if (fill) begin
            data_q[victim][fill_idx] <= bus.mem_rdata;
            tag_q[victim][fill_idx]  <= fill_tag;
        end else if (wr_hit) begin
            if (word)
                data_q[hit_way][idx][63:32] <= bus.write_data;
            else
                data_q[hit_way][idx][31:0]  <= bus.write_data;
        end
    end

    assign bus.ready      = ready_c;
    assign bus.read_data  = rdata_c;
    assign bus.mem_rd_en  = mem_rd_en_q;
    assign bus.mem_wr_en  = mem_wr_en_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = bus.write_data;
    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;
endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed self-checking bench for cache_controller
module tb_cache_controller;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    cache_controller_if #(.ADDR_W(19), .CNT_W(16)) bus ();

    cache_controller #(
        .ADDR_W  (19),
        .SET_BITS(6),
        .CNT_W   (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts and ends one time unit after a rising edge; outputs sampled mid-cycle
    task automatic do_read(input logic [18:0] a, input logic [63:0] line,
                           output logic hit, output logic [31:0] data);
        bus.address = a;
        bus.rd_en   = 1'b1;
        #4;
        hit  = bus.ready;
        data = bus.read_data;
        if (!hit) begin
            @(posedge clk); #1;
            bus.mem_rdata = line;
            bus.mem_ready = 1'b1;
            #4;
            data = bus.read_data;
        end
        @(posedge clk); #1;
        bus.rd_en     = 1'b0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic do_write(input logic [18:0] a, input logic [31:0] d,
                            output logic wr_seen, output logic [18:0] addr_seen,
                            output logic rdy_seen);
        bus.address    = a;
        bus.write_data = d;
        bus.wr_en      = 1'b1;
        @(posedge clk); #1;
        wr_seen   = bus.mem_wr_en;
        addr_seen = bus.mem_addr;
        bus.mem_ready = 1'b1;
        #4;
        rdy_seen = bus.ready;
        @(posedge clk); #1;
        bus.wr_en     = 1'b0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset;
        #4;
        n_checks++;
        if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
        n_checks++;
        if (bus.read_data !== 32'h0) begin n_fail++; $display("FAIL reset_read_data: got %h expected 0", bus.read_data); end
        n_checks++;
        if ({bus.mem_rd_en, bus.mem_wr_en} !== 2'b00) begin n_fail++; $display("FAIL reset_mem_en: got %b expected 00", {bus.mem_rd_en, bus.mem_wr_en}); end
        n_checks++;
        if (bus.mem_addr !== 19'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
        n_checks++;
        if ({bus.hit_count, bus.miss_count} !== 32'h0) begin n_fail++; $display("FAIL reset_counters: got %h expected 0", {bus.hit_count, bus.miss_count}); end
        @(posedge clk); #1;
    endtask

    task automatic test_cold_read;
        bus.address = 19'h00010;
        bus.rd_en   = 1'b1;
        #4;
        n_checks++;
        if ({bus.ready, bus.mem_rd_en} !== 2'b00) begin n_fail++; $display("FAIL cold_first_cycle: got ready,mem_rd_en=%b expected 00", {bus.ready, bus.mem_rd_en}); end
        @(posedge clk); #1;
        n_checks++;
        if ({bus.mem_rd_en, bus.mem_addr} !== {1'b1, 19'h00010}) begin n_fail++; $display("FAIL cold_mem_req: got en=%b addr=%h expected en=1 addr=00010", bus.mem_rd_en, bus.mem_addr); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.ready, bus.mem_rd_en, bus.read_data} !== {2'b01, 32'h0}) begin n_fail++; $display("FAIL cold_wait: got ready=%b en=%b data=%h expected 0 1 0", bus.ready, bus.mem_rd_en, bus.read_data); end
        bus.mem_rdata = 64'h11111111_22222222;
        bus.mem_ready = 1'b1;
        #4;
        n_checks++;
        if ({bus.ready, bus.read_data} !== {1'b1, 32'h22222222}) begin n_fail++; $display("FAIL cold_fill_data: got ready=%b data=%h expected 1 22222222", bus.ready, bus.read_data); end
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        bus.rd_en     = 1'b0;
        n_checks++;
        if (bus.mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL cold_mem_rd_drop: got %b expected 0", bus.mem_rd_en); end
        bus.address = 19'h00014;
        bus.rd_en   = 1'b1;
        #4;
        n_checks++;
        if ({bus.ready, bus.read_data} !== {1'b1, 32'h11111111}) begin n_fail++; $display("FAIL cold_rehit: got ready=%b data=%h expected 1 11111111", bus.ready, bus.read_data); end
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
        n_checks++;
        if ({bus.hit_count, bus.miss_count} !== {16'd1, 16'd1}) begin n_fail++; $display("FAIL cold_counters: got hit=%0d miss=%0d expected 1 1", bus.hit_count, bus.miss_count); end
    endtask

    task automatic test_lru;
        logic        h;
        logic [31:0] d;
        do_read(19'h00000, 64'hA1A1A1A1_A0A0A0A0, h, d);
        do_read(19'h00200, 64'hB1B1B1B1_B0B0B0B0, h, d);
        do_read(19'h00400, 64'hC1C1C1C1_C0C0C0C0, h, d);
        n_checks++;
        if ({h, d} !== {1'b0, 32'hC0C0C0C0}) begin n_fail++; $display("FAIL lru_third_miss: got hit=%b data=%h expected 0 C0C0C0C0", h, d); end
        do_read(19'h00200, 64'hEEEEEEEE_EEEEEEEE, h, d);
        n_checks++;
        if ({h, d} !== {1'b1, 32'hB0B0B0B0}) begin n_fail++; $display("FAIL lru_keep_mru: got hit=%b data=%h expected 1 B0B0B0B0", h, d); end
        do_read(19'h00004, 64'hD1D1D1D1_D0D0D0D0, h, d);
        n_checks++;
        if ({h, d} !== {1'b0, 32'hD1D1D1D1}) begin n_fail++; $display("FAIL lru_evicted: got hit=%b data=%h expected 0 D1D1D1D1", h, d); end
        n_checks++;
        if ({bus.hit_count, bus.miss_count} !== {16'd2, 16'd5}) begin n_fail++; $display("FAIL lru_counters: got hit=%0d miss=%0d expected 2 5", bus.hit_count, bus.miss_count); end
    endtask

    task automatic test_write_hit;
        logic        w, r, h;
        logic [18:0] a;
        logic [31:0] d;
        bus.address    = 19'h00010;
        bus.write_data = 32'hDEADBEEF;
        bus.wr_en      = 1'b1;
        bus.rd_en      = 1'b1;
        #4;
        n_checks++;
        if ({bus.ready, bus.mem_wdata} !== {1'b0, 32'hDEADBEEF}) begin n_fail++; $display("FAIL wr_first_cycle: got ready=%b wdata=%h expected 0 DEADBEEF", bus.ready, bus.mem_wdata); end
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        do_write(19'h00010, 32'hDEADBEEF, w, a, r);
        n_checks++;
        if ({w, a, r} !== {1'b1, 19'h00010, 1'b1}) begin n_fail++; $display("FAIL wr_hit_mem: got en=%b addr=%h ready=%b expected 1 00010 1", w, a, r); end
        n_checks++;
        if (bus.mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL wr_hit_drop: got %b expected 0", bus.mem_wr_en); end
        do_read(19'h00010, 64'h0, h, d);
        n_checks++;
        if ({h, d} !== {1'b1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL wr_hit_readback: got hit=%b data=%h expected 1 DEADBEEF", h, d); end
        do_read(19'h00014, 64'h0, h, d);
        n_checks++;
        if ({h, d} !== {1'b1, 32'h11111111}) begin n_fail++; $display("FAIL wr_hit_other_word: got hit=%b data=%h expected 1 11111111", h, d); end
    endtask

    task automatic test_write_miss;
        logic        w, r, h;
        logic [18:0] a;
        logic [31:0] d;
        do_write(19'h7FF00, 32'hCAFEF00D, w, a, r);
        n_checks++;
        if ({w, a, r} !== {1'b1, 19'h7FF00, 1'b1}) begin n_fail++; $display("FAIL wr_miss_mem: got en=%b addr=%h ready=%b expected 1 7FF00 1", w, a, r); end
        do_read(19'h7FF00, 64'h87654321_12345678, h, d);
        n_checks++;
        if ({h, d} !== {1'b0, 32'h12345678}) begin n_fail++; $display("FAIL wr_miss_no_alloc: got hit=%b data=%h expected 0 12345678", h, d); end
        n_checks++;
        if ({bus.hit_count, bus.miss_count} !== {16'd4, 16'd6}) begin n_fail++; $display("FAIL wr_counters: got hit=%0d miss=%0d expected 4 6", bus.hit_count, bus.miss_count); end
    endtask

    task automatic test_invalidate;
        logic        h;
        logic [31:0] d;
        bus.invalidate = 1'b1;
        @(posedge clk); #1;
        bus.invalidate = 1'b0;
        do_read(19'h00010, 64'h33333333_44444444, h, d);
        n_checks++;
        if ({h, d} !== {1'b0, 32'h44444444}) begin n_fail++; $display("FAIL inv_miss_a: got hit=%b data=%h expected 0 44444444", h, d); end
        do_read(19'h00200, 64'h55555555_66666666, h, d);
        n_checks++;
        if (h !== 1'b0) begin n_fail++; $display("FAIL inv_miss_b: got hit=%b expected 0", h); end
        bus.address = 19'h00040;
        bus.rd_en   = 1'b1;
        @(posedge clk); #1;
        bus.invalidate = 1'b1;
        @(posedge clk); #1;
        bus.invalidate = 1'b0;
        bus.mem_rdata  = 64'h77777777_88888888;
        bus.mem_ready  = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        bus.rd_en     = 1'b0;
        do_read(19'h00014, 64'h0, h, d);
        n_checks++;
        if ({h, d} !== {1'b1, 32'h33333333}) begin n_fail++; $display("FAIL inv_ignored_in_miss: got hit=%b data=%h expected 1 33333333", h, d); end
        do_read(19'h00040, 64'h0, h, d);
        n_checks++;
        if ({h, d} !== {1'b1, 32'h88888888}) begin n_fail++; $display("FAIL inv_fill_kept: got hit=%b data=%h expected 1 88888888", h, d); end
        n_checks++;
        if ({bus.hit_count, bus.miss_count} !== {16'd6, 16'd9}) begin n_fail++; $display("FAIL inv_counters: got hit=%0d miss=%0d expected 6 9", bus.hit_count, bus.miss_count); end
    endtask

    task automatic test_reset_mid_miss;
        logic        h;
        logic [31:0] d;
        bus.address = 19'h00080;
        bus.rd_en   = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.mem_rd_en !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got mem_rd_en=%b expected 1", bus.mem_rd_en); end
        rst         = 1'b0;
        bus.rd_en   = 1'b0;
        #1;
        n_checks++;
        if ({bus.mem_rd_en, bus.ready, bus.hit_count, bus.miss_count} !== {2'b01, 32'h0}) begin n_fail++; $display("FAIL rst_mid_abort: got en=%b ready=%b hit=%0d miss=%0d expected 0 1 0 0", bus.mem_rd_en, bus.ready, bus.hit_count, bus.miss_count); end
        bus.mem_rdata = 64'h99999999_99999999;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        do_read(19'h00080, 64'hABABABAB_12121212, h, d);
        n_checks++;
        if ({h, d} !== {1'b0, 32'h12121212}) begin n_fail++; $display("FAIL rst_mid_after: got hit=%b data=%h expected 0 12121212", h, d); end
        n_checks++;
        if ({bus.hit_count, bus.miss_count} !== {16'd0, 16'd1}) begin n_fail++; $display("FAIL rst_mid_counters: got hit=%0d miss=%0d expected 0 1", bus.hit_count, bus.miss_count); end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b0;
        bus.rd_en      = 1'b0;
        bus.wr_en      = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;
        bus.invalidate = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        test_reset();
        test_cold_read();
        test_lru();
        test_write_hit();
        test_write_miss();
        test_invalidate();
        test_reset_mid_miss();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
# cache_controller

Parametrised 2-way set-associative, write-through, no-write-allocate data cache between the MEM stage and the SRAM controller. It replaces the direct MEM→SRAM path so that read hits complete in the same cycle without freezing the pipeline. Misses and all writes go to the lower-level memory port. Hit and miss statistics are kept in saturating counters.

## Interface
Parameters:
- ADDR_W, 19: byte-address width of the data space; the base offset is already removed by the caller.
- SET_BITS, 6: index width, giving 2^SET_BITS sets; each set has 2 ways of one 64-bit line (2 words).
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- rd_en  in  1  load request from MEM stage.
- wr_en  in  1  store request from MEM stage.
- address  in  ADDR_W  byte address; bits [1:0] ignored.
- write_data  in  32  store data.
- invalidate  in  1  one-cycle pulse that clears all valid bits.
- read_data  out  32  load result, valid when ready=1 and rd_en=1.
- ready  out  1  request complete; low means freeze the pipeline.
- mem_rd_en  out  1  line-read request to the SRAM controller.
- mem_wr_en  out  1  word-write request to the SRAM controller.
- mem_addr  out  ADDR_W  address to the SRAM controller; low 3 bits are 0 for reads.
- mem_wdata  out  32  write data, equal to write_data.
- mem_rdata  in  64  line returned by the SRAM controller; word 0 is in [31:0].
- mem_ready  in  1  one-cycle completion pulse from the SRAM controller.
- hit_count  out  CNT_W  read hits, saturating.
- miss_count  out  CNT_W  read misses, saturating.

## Operation
- Address split: word select = address[2]; index = address[SET_BITS+2:3]; tag = address[ADDR_W-1:SET_BITS+3].
- Per-set storage: valid[2], tag[2], data[2] (64 bits each), and one LRU bit that names the way to evict next.
- Hit: the way is valid and its tag matches. Both ways matching cannot occur.
- FSM states:
  - IDLE. If wr_en → WRITE. Else if rd_en and miss → RD_MISS. Else stay in IDLE.
  - RD_MISS. On mem_ready: write mem_rdata into the LRU way, set valid, set tag, point LRU at the other way, drive read_data from the selected word of mem_rdata, go to IDLE.
  - WRITE. On mem_ready → IDLE.
- Read hit in IDLE: the data comes from the hitting way. LRU is updated to point at the other way. hit_count increments.
- Read miss: miss_count increments once, on the IDLE→RD_MISS edge.
- Write hit: the addressed word in the hitting way is updated on entry to WRITE, and LRU is updated. Write miss: the cache is left unchanged. In both cases the memory is written.
- Priority: wr_en and rd_en asserted together is illegal; wr_en wins.
- invalidate is honoured only in IDLE with no request. It clears every valid bit and leaves tags, data and LRU unchanged. In any other state it is ignored.
- Counters stop at 2^CNT_W−1.

## Timing
- Reset (rst=0): state=IDLE. All valid bits, LRU bits and counters are 0. mem_rd_en=0, mem_wr_en=0, mem_addr=0. ready=1 and read_data=0 while no request is present.
- ready is combinational:
  - 1 in IDLE when there is no request or on a read hit.
  - 1 in RD_MISS or WRITE during the mem_ready cycle.
  - 0 otherwise.
- read_data is 0 whenever ready=0.
- Read hit: zero added latency.
- Read miss: one cycle to enter RD_MISS, plus the memory latency. mem_rd_en is registered and held high until mem_ready.
- Write: the same timing as a read miss, with mem_wr_en held high.
- mem_addr is registered on the transition out of IDLE and held until the state returns to IDLE.
- The requester holds address, write_data, rd_en and wr_en stable while ready=0. The cache does not re-sample them.
- mem_ready outside RD_MISS or WRITE is ignored.
- Reset asserted mid-miss or mid-write aborts the transaction immediately. No line is filled and no counter changes.

## Test plan
- Cold read at 0x00010 → ready=0, mem_rd_en on the next cycle. mem_rdata=0x11111111_22222222 arriving after 3 cycles → read_data=0x22222222 with ready=1. Re-read 0x00014 → same-cycle ready, 0x11111111, hit_count=1, miss_count=1.
- Conflict and LRU: read 0x00000, 0x00200, then 0x00400 (same index, SET_BITS=6) → the third read evicts the 0x00000 line. Re-reading 0x00200 hits; re-reading 0x00000 misses.
- Write hit at 0x00010 with 0xDEADBEEF → mem_wr_en asserted, mem_addr=0x00010, ready with mem_ready. A following read of 0x00010 hits and returns 0xDEADBEEF.
- Write miss at 0x7FF00 → memory is written. A following read of 0x7FF00 misses, which shows no allocation on write.
- invalidate pulse in idle after lines are filled → all previously hitting addresses miss. A pulse during RD_MISS has no effect.
- rst driven low during RD_MISS, before mem_ready → mem_rd_en=0 immediately, ready=1, counters=0. After release, a read of the same address misses.
